// File: rtl/mc_inject_ctrl_pkg.sv
// Shared types and direction masks for the multicast injection controller.
// Direction order on port vectors is N, E, S, W, L.
package mc_inject_ctrl_pkg;

  localparam int NUM_PORT       = 5;
  localparam int DST_LIST_WIDTH = 16;

  typedef logic [DST_LIST_WIDTH-1:0] dst_t;
  typedef logic [NUM_PORT-1:0]       pv_t;

  localparam dst_t N_MASK = 16'h000F;
  localparam dst_t E_MASK = 16'h00F0;
  localparam dst_t S_MASK = 16'h0F00;
  localparam dst_t W_MASK = 16'hF000;
  // The local port never appears in a destination list.
  localparam dst_t L_MASK = 16'h0000;

  localparam dst_t DIR_MASK [NUM_PORT] = '{
    N_MASK, E_MASK, S_MASK, W_MASK, L_MASK
  };

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/mc_inject_ctrl_if.sv
// Injection and allocator handshake bundle for mc_inject_ctrl.
// master drives offers and grants; slave is the controller.
interface mc_inject_ctrl_if
  import mc_inject_ctrl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 4
) ();

  logic              inj_valid;
  dst_t              inj_dst;
  logic [DATA_W-1:0] inj_data;
  logic              inj_ready;
  logic              req_valid;
  dst_t              req_dst;
  logic [DATA_W-1:0] req_data;
  pv_t               req_ppv;
  logic              req_golden;
  pv_t               grant_pv;
  logic [CNT_W-1:0]  wait_cnt;

  modport master (
    output inj_valid, inj_dst, inj_data, grant_pv,
    input  inj_ready, req_valid, req_dst, req_data,
    input  req_ppv, req_golden, wait_cnt
  );

  modport slave (
    input  inj_valid, inj_dst, inj_data, grant_pv,
    output inj_ready, req_valid, req_dst, req_data,
    output req_ppv, req_golden, wait_cnt
  );

endinterface

// File: rtl/mc_dir_mask.sv
// Direction vector to destination-list mask, plus the
// per-direction productive-port reduction of a list.
module mc_dir_mask
  import mc_inject_ctrl_pkg::*;
(
  input  pv_t  dir,
  input  dst_t dst,
  output dst_t mask,
  output pv_t  ppv
);

  always_comb begin
    mask = '0;
    ppv  = '0;
    for (int d = 0; d < NUM_PORT; d++) begin
      if (dir[d]) mask = mask | DIR_MASK[d];
      ppv[d] = |(dst & DIR_MASK[d]);
    end
  end

endmodule

// File: rtl/mc_inject_ctrl.sv
// Holds one injected multicast flit and re-requests its unserved
// destinations until all are covered; flags starvation.
module mc_inject_ctrl
  import mc_inject_ctrl_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int STARVE_TH = 8,
  parameter int CNT_W     = 4
) (
  input logic             clk,
  input logic             reset,
  mc_inject_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] TH      = CNT_W'(STARVE_TH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  dst_t              rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dst_t              served;
  pv_t               ppv;

  mc_dir_mask u_mask (
    .dir  (bus.grant_pv),
    .dst  (rem_q),
    .mask (served),
    .ppv  (ppv)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A zero list is accepted and dropped without leaving IDLE.
        if (bus.inj_valid && bus.inj_dst != '0) begin
          state_d = ACTIVE;
          rem_d   = bus.inj_dst;
          data_d  = bus.inj_data;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        rem_d = rem_q & ~served;
        if ((served & rem_q) != '0)
          cnt_d = '0;
        else if (cnt_q != CNT_MAX)
          cnt_d = cnt_q + 1'b1;
        if (rem_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.inj_ready  = (state_q == IDLE);
    bus.req_valid  = (state_q == ACTIVE);
    bus.req_dst    = rem_q;
    bus.req_data   = (state_q == ACTIVE) ? data_q : '0;
    bus.req_ppv    = ppv;
    bus.req_golden = (state_q == ACTIVE) && (cnt_q >= TH);
    bus.wait_cnt   = cnt_q;
  end

endmodule
